// File: rtl/qspi_read_engine.sv
// Quad-SPI Fast Read Quad Output (0x6B) master. Returned bytes go out on a valid/ready byte port.
// SCK comes from a clock-enable divider on mclk, so the whole block runs in one clock domain.
module qspi_read_engine #(
    parameter int unsigned CLK_DIV      = 2,
    parameter int unsigned DUMMY_CYCLES = 8,
    parameter int unsigned CS_HIGH_CYC  = 4
) (
    input  logic        mclk,
    input  logic        RESET,
    input  logic        start,
    input  logic [23:0] addr,
    input  logic [15:0] len,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    output logic [7:0]  rd_data,
    output logic        rd_valid,
    input  logic        rd_ready,
    output logic        sck,
    output logic        cs_n,
    output logic [3:0]  io_out,
    output logic [3:0]  io_oe,
    input  logic [3:0]  io_in
);

    localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned CYC_MAX = (DUMMY_CYCLES > 24) ? DUMMY_CYCLES : 24;
    localparam int unsigned CYC_W   = $clog2(CYC_MAX);
    localparam int unsigned HOLD_W  = (CS_HIGH_CYC > 1) ? $clog2(CS_HIGH_CYC) : 1;

    localparam logic [7:0] CMD_QOR  = 8'h6B;
    localparam logic [3:0] OE_SPI   = 4'b1101;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_CS_SETUP = 3'd1;
    localparam logic [2:0] ST_CMD      = 3'd2;
    localparam logic [2:0] ST_ADDR     = 3'd3;
    localparam logic [2:0] ST_DUMMY    = 3'd4;
    localparam logic [2:0] ST_DATA     = 3'd5;
    localparam logic [2:0] ST_CS_HOLD  = 3'd6;

    logic [2:0]        state,    state_nxt;
    logic [DIV_W-1:0]  div_cnt,  div_nxt;
    logic [CYC_W-1:0]  cyc_cnt,  cyc_nxt;
    logic [HOLD_W-1:0] hold_cnt, hold_nxt;
    logic [30:0]       tx_sr,    tx_sr_nxt;
    logic [15:0]       byte_cnt, byte_cnt_nxt;
    logic [3:0]        hi_nib,   hi_nib_nxt;
    logic              nib_lo,   nib_lo_nxt;
    logic              last_seen, last_nxt;
    logic              aborted,  aborted_nxt;
    logic              sck_nxt, cs_n_nxt, busy_nxt, done_nxt, rd_valid_nxt;
    logic [7:0]        rd_data_nxt;
    logic [3:0]        io_out_nxt, io_oe_nxt;
    logic              tick;
    logic [CYC_W-1:0]  cyc_last;

    assign tick = (div_cnt == DIV_W'(CLK_DIV - 1));

    // Number of SCK cycles (minus one) spent in the current serial phase
    always_comb begin
        cyc_last = CYC_W'(7);
        if (state == ST_ADDR) begin
            cyc_last = CYC_W'(23);
        end else if (state == ST_DUMMY) begin
            cyc_last = CYC_W'(DUMMY_CYCLES - 1);
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt    = state;
        div_nxt      = div_cnt;
        cyc_nxt      = cyc_cnt;
        hold_nxt     = hold_cnt;
        tx_sr_nxt    = tx_sr;
        byte_cnt_nxt = byte_cnt;
        hi_nib_nxt   = hi_nib;
        nib_lo_nxt   = nib_lo;
        last_nxt     = last_seen;
        aborted_nxt  = aborted;
        sck_nxt      = sck;
        cs_n_nxt     = cs_n;
        busy_nxt     = busy;
        done_nxt     = 1'b0;
        rd_valid_nxt = rd_valid;
        rd_data_nxt  = rd_data;
        io_out_nxt   = io_out;
        io_oe_nxt    = io_oe;

        if (rd_valid && rd_ready) begin
            rd_valid_nxt = 1'b0;
        end

        // SCK divider only runs while the bus is active
        if (state == ST_IDLE || state == ST_CS_HOLD) begin
            div_nxt = '0;
        end else if (tick) begin
            div_nxt = '0;
        end else begin
            div_nxt = div_cnt + DIV_W'(1);
        end

        case (state)
            ST_IDLE: begin
                if (start && (len != 16'd0)) begin
                    state_nxt    = ST_CS_SETUP;
                    tx_sr_nxt    = {CMD_QOR[6:0], addr};
                    byte_cnt_nxt = len;
                    busy_nxt     = 1'b1;
                    cs_n_nxt     = 1'b0;
                    io_oe_nxt    = OE_SPI;
                    io_out_nxt   = {3'b110, CMD_QOR[7]};
                    cyc_nxt      = '0;
                    nib_lo_nxt   = 1'b0;
                    last_nxt     = 1'b0;
                    aborted_nxt  = 1'b0;
                end
            end

            ST_CS_SETUP: begin
                if (tick) begin
                    state_nxt = ST_CMD;
                end
            end

            ST_CMD, ST_ADDR, ST_DUMMY: begin
                if (tick) begin
                    if (!sck) begin
                        sck_nxt = 1'b1;
                    end else begin
                        sck_nxt = 1'b0;
                        if (state != ST_DUMMY) begin
                            io_out_nxt = {3'b110, tx_sr[30]};
                            tx_sr_nxt  = {tx_sr[29:0], 1'b0};
                        end
                        if (cyc_cnt == cyc_last) begin
                            cyc_nxt = '0;
                            if (state == ST_CMD) begin
                                state_nxt = ST_ADDR;
                            end else if (state == ST_ADDR) begin
                                state_nxt = ST_DUMMY;
                                io_oe_nxt = '0;
                            end else begin
                                state_nxt = ST_DATA;
                            end
                        end else begin
                            cyc_nxt = cyc_cnt + CYC_W'(1);
                        end
                    end
                end
            end

            ST_DATA: begin
                if (last_seen && !sck) begin
                    state_nxt = ST_CS_HOLD;
                    cs_n_nxt  = 1'b1;
                    hold_nxt  = '0;
                end else if (tick) begin
                    if (sck) begin
                        sck_nxt = 1'b0;
                    end else if (!nib_lo) begin
                        sck_nxt    = 1'b1;
                        hi_nib_nxt = io_in;
                        nib_lo_nxt = 1'b1;
                    end else if (!(rd_valid && !rd_ready)) begin
                        // Second-nibble edge is withheld while the previous byte is still pending
                        sck_nxt      = 1'b1;
                        nib_lo_nxt   = 1'b0;
                        rd_data_nxt  = {hi_nib, io_in};
                        rd_valid_nxt = 1'b1;
                        byte_cnt_nxt = byte_cnt - 16'd1;
                        if (byte_cnt == 16'd1) begin
                            last_nxt = 1'b1;
                        end
                    end
                end
            end

            ST_CS_HOLD: begin
                if (hold_cnt != HOLD_W'(CS_HIGH_CYC - 1)) begin
                    hold_nxt = hold_cnt + HOLD_W'(1);
                end else if (!rd_valid || rd_ready) begin
                    state_nxt = ST_IDLE;
                    busy_nxt  = 1'b0;
                    done_nxt  = !aborted;
                end
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // Abort wins over everything, including a byte loading this cycle
        if (abort && (state != ST_IDLE)) begin
            state_nxt    = ST_CS_HOLD;
            cs_n_nxt     = 1'b1;
            sck_nxt      = 1'b0;
            io_oe_nxt    = '0;
            rd_valid_nxt = 1'b0;
            hold_nxt     = '0;
            aborted_nxt  = 1'b1;
            done_nxt     = 1'b0;
        end
    end

    // State and output registers
    always_ff @(posedge mclk) begin
        if (RESET) begin
            state     <= ST_IDLE;
            div_cnt   <= '0;
            cyc_cnt   <= '0;
            hold_cnt  <= '0;
            tx_sr     <= '0;
            byte_cnt  <= '0;
            hi_nib    <= '0;
            nib_lo    <= 1'b0;
            last_seen <= 1'b0;
            aborted   <= 1'b0;
            sck       <= 1'b0;
            cs_n      <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
            io_out    <= '0;
            io_oe     <= '0;
        end else begin
            state     <= state_nxt;
            div_cnt   <= div_nxt;
            cyc_cnt   <= cyc_nxt;
            hold_cnt  <= hold_nxt;
            tx_sr     <= tx_sr_nxt;
            byte_cnt  <= byte_cnt_nxt;
            hi_nib    <= hi_nib_nxt;
            nib_lo    <= nib_lo_nxt;
            last_seen <= last_nxt;
            aborted   <= aborted_nxt;
            sck       <= sck_nxt;
            cs_n      <= cs_n_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            rd_valid  <= rd_valid_nxt;
            rd_data   <= rd_data_nxt;
            io_out    <= io_out_nxt;
            io_oe     <= io_oe_nxt;
        end
    end

endmodule

// File: tb/tb_qspi_read_engine.sv
// Directed bench for qspi_read_engine with a behavioural 0x6B flash and a byte scoreboard.
module tb_qspi_read_engine;

    logic        mclk     = 1'b0;
    logic        RESET    = 1'b1;
    logic        start    = 1'b0;
    logic [23:0] addr     = '0;
    logic [15:0] len      = '0;
    logic        abort    = 1'b0;
    logic        rd_ready = 1'b0;
    logic [3:0]  io_in    = '0;
    logic        busy, done, rd_valid, sck, cs_n;
    logic [7:0]  rd_data;
    logic [3:0]  io_out, io_oe;

    qspi_read_engine #(.CLK_DIV(2), .DUMMY_CYCLES(8), .CS_HIGH_CYC(4)) dut (
        .mclk(mclk), .RESET(RESET), .start(start), .addr(addr), .len(len),
        .abort(abort), .busy(busy), .done(done), .rd_data(rd_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .sck(sck), .cs_n(cs_n),
        .io_out(io_out), .io_oe(io_oe), .io_in(io_in)
    );

    always #5 mclk = ~mclk;

    int n_chk  = 0;
    int n_fail = 0;
    int done_cnt, valid_cyc, popped;
    int sck_edges = 0;
    logic [7:0] sb[$];

    // Flash model: samples IO0 on rising SCK, drives nibbles on falling SCK after the dummy cycles
    logic [7:0]  fl_data[$];
    int          fl_rise = 0;
    int          fl_bad  = 0;
    int          fl_n;
    logic [7:0]  fl_cmd  = '0;
    logic [7:0]  fl_byte;
    logic [23:0] fl_addr = '0;

    always @(posedge sck or negedge cs_n) begin
        if (!sck) begin
            fl_rise = 0;
            fl_cmd  = '0;
            fl_addr = '0;
        end else if (!cs_n) begin
            if (fl_rise < 32) begin
                if (io_oe !== 4'b1101 || io_out[3:1] !== 3'b110) fl_bad++;
                if (fl_rise < 8) fl_cmd = {fl_cmd[6:0], io_out[0]};
                else             fl_addr = {fl_addr[22:0], io_out[0]};
            end else if (io_oe !== 4'b0000) begin
                fl_bad++;
            end
            fl_rise++;
        end
    end

    always @(negedge sck) begin
        if (!cs_n && fl_rise >= 40) begin
            fl_n    = fl_rise - 40;
            fl_byte = (fl_n / 2 < fl_data.size()) ? fl_data[fl_n / 2] : 8'h00;
            io_in   = fl_n[0] ? fl_byte[3:0] : fl_byte[7:4];
        end
    end

    always @(posedge sck) sck_edges++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: pops an expected byte on every handshake seen away from the clock edge
    task automatic monitor();
        logic [7:0] exp;
        forever begin
            @(negedge mclk);
            if (!RESET) begin
                if (done) done_cnt++;
                if (rd_valid) valid_cyc++;
                if (rd_valid && rd_ready) begin
                    popped++;
                    if (sb.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $error("FAIL sb_unexpected: observed byte %0h expected none", rd_data);
                    end else begin
                        exp = sb.pop_front();
                        chk("rd_data", 32'(rd_data), 32'(exp));
                    end
                end
            end
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge mclk);
            #1;
        end
    endtask

    task automatic do_start(input logic [23:0] a, input logic [15:0] l);
        start = 1'b1;
        addr  = a;
        len   = l;
        cyc(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max);
        int i = 0;
        while (done_cnt == 0 && i < max) begin
            cyc(1);
            i++;
        end
        chk(tag, 32'(done_cnt != 0), 32'd1);
        cyc(2);
    endtask

    task automatic load_flash();
        foreach (fl_data[i]) sb.push_back(fl_data[i]);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int i;
        int edges0;
        done_cnt = 0; valid_cyc = 0; popped = 0;
        fork
            monitor();
        join_none

        // 1: reset values
        repeat (3) @(posedge mclk);
        #1;
        chk("rst_cs_n", 32'(cs_n), 32'd1);
        chk("rst_sck", 32'(sck), 32'd0);
        chk("rst_io_oe", 32'(io_oe), 32'd0);
        chk("rst_io_out", 32'(io_out), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        RESET = 1'b0;
        cyc(5);
        chk("rst_no_sck", 32'(sck_edges), 32'd0);
        chk("rst_busy_idle", 32'(busy), 32'd0);

        // 2: basic 4-byte read with consumer always ready
        fl_data = '{8'hA5, 8'h3C, 8'hF0, 8'h0F};
        load_flash();
        rd_ready = 1'b1; done_cnt = 0; popped = 0;
        do_start(24'h012345, 16'd4);
        chk("t2_busy", 32'(busy), 32'd1);
        chk("t2_cs_low", 32'(cs_n), 32'd0);
        wait_done("t2_done_seen", 2000);
        chk("t2_cmd", 32'(fl_cmd), 32'h6B);
        chk("t2_addr", 32'(fl_addr), 32'h012345);
        chk("t2_edges", 32'(fl_rise), 32'd48);
        chk("t2_done_once", 32'(done_cnt), 32'd1);
        chk("t2_bytes", 32'(popped), 32'd4);
        chk("t2_busy_end", 32'(busy), 32'd0);
        chk("t2_cs_end", 32'(cs_n), 32'd1);

        // 3: back-pressure holds byte 1 and the second-nibble edge of byte 2
        load_flash();
        rd_ready = 1'b0; done_cnt = 0; popped = 0;
        do_start(24'h012345, 16'd4);
        i = 0;
        while (!rd_valid && i < 1000) begin
            cyc(1);
            i++;
        end
        chk("t3_first_valid", 32'(rd_valid), 32'd1);
        cyc(20);
        chk("t3_sck_held", 32'(sck), 32'd0);
        chk("t3_rd_data_held", 32'(rd_data), 32'hA5);
        chk("t3_valid_held", 32'(rd_valid), 32'd1);
        chk("t3_edges_held", 32'(fl_rise), 32'd43);
        rd_ready = 1'b1;
        wait_done("t3_done_seen", 2000);
        chk("t3_edges", 32'(fl_rise), 32'd48);
        chk("t3_bytes", 32'(popped), 32'd4);
        chk("t3_done_once", 32'(done_cnt), 32'd1);
        chk("t3_sb_empty", 32'(sb.size()), 32'd0);

        // 4: abort in the address phase, then a clean single-byte read
        fl_data = '{8'h11, 8'h22};
        done_cnt = 0; valid_cyc = 0; popped = 0;
        do_start(24'hABCDEF, 16'd2);
        i = 0;
        while (fl_rise < 18 && i < 1000) begin
            cyc(1);
            i++;
        end
        abort = 1'b1;
        cyc(1);
        abort = 1'b0;
        chk("t4_cs_n", 32'(cs_n), 32'd1);
        chk("t4_sck", 32'(sck), 32'd0);
        chk("t4_io_oe", 32'(io_oe), 32'd0);
        cyc(3);
        chk("t4_busy_hold", 32'(busy), 32'd1);
        cyc(1);
        chk("t4_busy_low", 32'(busy), 32'd0);
        chk("t4_rises", 32'(fl_rise), 32'd18);
        chk("t4_no_done", 32'(done_cnt), 32'd0);
        chk("t4_no_valid", 32'(valid_cyc), 32'd0);
        fl_data = '{8'h5A};
        load_flash();
        do_start(24'h000000, 16'd1);
        wait_done("t4b_done_seen", 2000);
        chk("t4b_addr", 32'(fl_addr), 32'h000000);
        chk("t4b_edges", 32'(fl_rise), 32'd42);
        chk("t4b_bytes", 32'(popped), 32'd1);
        chk("t4b_done_once", 32'(done_cnt), 32'd1);

        // 5: len==0 ignored; start while busy ignored
        done_cnt = 0; popped = 0;
        edges0 = sck_edges;
        do_start(24'h000100, 16'd0);
        cyc(4);
        chk("t5_len0_busy", 32'(busy), 32'd0);
        chk("t5_len0_cs", 32'(cs_n), 32'd1);
        chk("t5_len0_sck", 32'(sck_edges - edges0), 32'd0);
        fl_data = '{8'hC3, 8'h96};
        load_flash();
        do_start(24'h00ABCD, 16'd2);
        cyc(30);
        do_start(24'h777777, 16'd5);
        wait_done("t5_done_seen", 2000);
        chk("t5_addr", 32'(fl_addr), 32'h00ABCD);
        chk("t5_edges", 32'(fl_rise), 32'd44);
        chk("t5_bytes", 32'(popped), 32'd2);
        chk("t5_done_once", 32'(done_cnt), 32'd1);
        cyc(20);
        chk("t5_no_restart", 32'(busy), 32'd0);

        // 6: top address, last byte left pending past the end of the transfer
        fl_data = '{8'hE7};
        load_flash();
        rd_ready = 1'b0; done_cnt = 0; popped = 0;
        do_start(24'hFFFFFF, 16'd1);
        i = 0;
        while (!cs_n && i < 1000) begin
            cyc(1);
            i++;
        end
        chk("t6_cs_rise", 32'(cs_n), 32'd1);
        cyc(10);
        chk("t6_no_done", 32'(done_cnt), 32'd0);
        chk("t6_busy", 32'(busy), 32'd1);
        chk("t6_valid", 32'(rd_valid), 32'd1);
        chk("t6_data", 32'(rd_data), 32'hE7);
        chk("t6_sck", 32'(sck), 32'd0);
        chk("t6_addr", 32'(fl_addr), 32'hFFFFFF);
        chk("t6_edges", 32'(fl_rise), 32'd42);
        rd_ready = 1'b1;
        wait_done("t6_done_seen", 200);
        chk("t6_bytes", 32'(popped), 32'd1);
        chk("t6_done_once", 32'(done_cnt), 32'd1);
        chk("t6_busy_end", 32'(busy), 32'd0);

        chk("io_drive", 32'(fl_bad), 32'd0);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
